// File: rtl/beam_gather.sv
// beam_gather: three ADC capture channels into per-channel FWFT FIFOs, re-emitted as
// FRAME_LEN-word frames on one AXI-stream. Define BEAM_GATHER_RR_EN for round-robin grant.
module beam_gather #(
  parameter int FRAME_LEN  = 1024,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  src_sel,
  input  logic [31:0] adc1_t_data,
  input  logic [31:0] adc2_t_data,
  input  logic [31:0] adc3_t_data,
  input  logic        adc1_t_valid,
  input  logic        adc2_t_valid,
  input  logic        adc3_t_valid,
  output logic [31:0] out_t_data,
  output logic        out_t_valid,
  input  logic        out_t_ready,
  output logic        out_t_last,
  output logic [1:0]  out_t_src,
  output logic [2:0]  ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, STREAM = 1'b1} state_t;

  state_t        state_r, state_nxt_s;
  logic [1:0]    grant_r, grant_nxt_s, sel_s;
  logic [CW-1:0] count_r, count_nxt_s;
  logic [2:0]    in_valid_s, empty_s, pop_s, ovf_s;
  logic [31:0]   in_data_s [3];
  logic [31:0]   head_s [3];
  logic [31:0]   head_sel_s;
  logic          empty_sel_s, hs_s;

  function automatic logic ch_empty(input logic [2:0] empty, input logic [1:0] ch);
    logic res;
    case (ch)
      2'd1:    res = empty[0];
      2'd2:    res = empty[1];
      2'd3:    res = empty[2];
      default: res = 1'b1;
    endcase
    return res;
  endfunction

  assign in_valid_s   = {adc3_t_valid, adc2_t_valid, adc1_t_valid};
  assign in_data_s[0] = adc1_t_data;
  assign in_data_s[1] = adc2_t_data;
  assign in_data_s[2] = adc3_t_data;

  generate
    for (genvar c = 0; c < 3; c++) begin : g_fifo
      logic [31:0] mem_r [FIFO_DEPTH];
      logic [AW:0] wr_ptr_r, rd_ptr_r;
      logic        full_s, push_s, ovf_r;

      assign empty_s[c] = (wr_ptr_r == rd_ptr_r);
      assign full_s     = (wr_ptr_r == {~rd_ptr_r[AW], rd_ptr_r[AW-1:0]});
      // A same-cycle pop frees a slot, so a full FIFO still accepts the write
      assign push_s     = in_valid_s[c] & (~full_s | pop_s[c]);
      assign head_s[c]  = mem_r[rd_ptr_r[AW-1:0]];
      assign ovf_s[c]   = ovf_r;

      // Pointer bookkeeping and sticky overflow flag
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          wr_ptr_r <= '0;
          rd_ptr_r <= '0;
          ovf_r    <= 1'b0;
        end else begin
          if (push_s) wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
          if (pop_s[c]) rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
          if (in_valid_s[c] & full_s & ~pop_s[c]) ovf_r <= 1'b1;
        end
      end

      // Sample storage; slots are only read after being written
      always_ff @(posedge clk) begin
        if (push_s) mem_r[wr_ptr_r[AW-1:0]] <= in_data_s[c];
      end
    end
  endgenerate

  // Route the granted FIFO head and empty flag to the output
  always_comb begin
    head_sel_s  = 32'd0;
    empty_sel_s = 1'b1;
    case (grant_r)
      2'd1:    begin head_sel_s = head_s[0]; empty_sel_s = empty_s[0]; end
      2'd2:    begin head_sel_s = head_s[1]; empty_sel_s = empty_s[1]; end
      2'd3:    begin head_sel_s = head_s[2]; empty_sel_s = empty_s[2]; end
      default: begin head_sel_s = 32'd0;     empty_sel_s = 1'b1;       end
    endcase
  end

  assign out_t_valid = (state_r == STREAM) & ~empty_sel_s;
  assign out_t_data  = out_t_valid ? head_sel_s : 32'd0;
  assign out_t_last  = out_t_valid & (count_r == LAST_CNT);
  assign out_t_src   = (state_r == STREAM) ? grant_r : 2'd0;
  assign hs_s        = out_t_valid & out_t_ready;
  assign pop_s       = {hs_s & (grant_r == 2'd3), hs_s & (grant_r == 2'd2), hs_s & (grant_r == 2'd1)};
  assign ovf         = ovf_s;

`ifdef BEAM_GATHER_RR_EN
  logic [1:0] rr_ptr_r, cand1_s, cand2_s, unused_sel_s;

  function automatic logic [1:0] ch_next(input logic [1:0] ch);
    logic [1:0] res;
    case (ch)
      2'd1:    res = 2'd2;
      2'd2:    res = 2'd3;
      default: res = 2'd1;
    endcase
    return res;
  endfunction

  assign unused_sel_s = src_sel;
  assign cand1_s      = ch_next(rr_ptr_r);
  assign cand2_s      = ch_next(cand1_s);

  // First non-empty channel scanning upward from the pointer
  always_comb begin
    if (!ch_empty(empty_s, rr_ptr_r)) sel_s = rr_ptr_r;
    else if (!ch_empty(empty_s, cand1_s)) sel_s = cand1_s;
    else if (!ch_empty(empty_s, cand2_s)) sel_s = cand2_s;
    else sel_s = 2'd0;
  end

  // Move the pointer past the channel whose frame just completed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rr_ptr_r <= 2'd1;
    else if (hs_s & out_t_last) rr_ptr_r <= ch_next(grant_r);
  end
`else
  // Fixed source: grant src_sel only when it names a non-empty channel
  always_comb begin
    if (ch_empty(empty_s, src_sel)) sel_s = 2'd0;
    else sel_s = src_sel;
  end
`endif

  // FSM state, grant and word count registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      grant_r <= 2'd0;
      count_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      grant_r <= grant_nxt_s;
      count_r <= count_nxt_s;
    end
  end

  // Next-state: grant in IDLE, count handshakes in STREAM
  always_comb begin
    state_nxt_s = state_r;
    grant_nxt_s = grant_r;
    count_nxt_s = count_r;
    case (state_r)
      IDLE: begin
        if (sel_s != 2'd0) begin
          grant_nxt_s = sel_s;
          count_nxt_s = '0;
          state_nxt_s = STREAM;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      STREAM: begin
        if (hs_s) begin
          if (out_t_last) begin
            state_nxt_s = IDLE;
            count_nxt_s = '0;
          end else begin
            count_nxt_s = count_r + CW'(1);
          end
        end else begin
          state_nxt_s = STREAM;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

endmodule

// File: tb/tb_beam_gather.sv
// Scoreboard bench for beam_gather: per-channel queue model of bounded FIFOs, monitor
// checks every handshake, frame boundaries, overflow flags and stall stability.
module tb_beam_gather;
  localparam int FL = 8;
  localparam int FD = 4;

  logic        clk, rst;
  logic [1:0]  src_sel;
  logic [31:0] adc1_t_data, adc2_t_data, adc3_t_data;
  logic        adc1_t_valid, adc2_t_valid, adc3_t_valid;
  logic [31:0] out_t_data;
  logic        out_t_valid, out_t_ready, out_t_last;
  logic [1:0]  out_t_src;
  logic [2:0]  ovf;

  beam_gather #(.FRAME_LEN(FL), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .src_sel(src_sel),
    .adc1_t_data(adc1_t_data), .adc2_t_data(adc2_t_data), .adc3_t_data(adc3_t_data),
    .adc1_t_valid(adc1_t_valid), .adc2_t_valid(adc2_t_valid), .adc3_t_valid(adc3_t_valid),
    .out_t_data(out_t_data), .out_t_valid(out_t_valid), .out_t_ready(out_t_ready),
    .out_t_last(out_t_last), .out_t_src(out_t_src), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic miss(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got nothing expected a recorded event", name);
  endtask

  // Reference model: one bounded queue per channel
  logic [31:0] q1[$], q2[$], q3[$];
  logic [2:0]  exp_ovf;
  int fcnt, last_hs_cyc, hs_total;
  bit fv_seen, after_last, prev_stall;
  logic [31:0] prev_data;
  logic [1:0]  frame_src;
  int fv_q[$], fr_first[$], fr_last[$], gap_q[$];
  logic [1:0] src_q[$];

  function automatic int qsize(input logic [1:0] c);
    case (c)
      2'd1: return q1.size();
      2'd2: return q2.size();
      2'd3: return q3.size();
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] qpop(input logic [1:0] c);
    case (c)
      2'd1: return q1.pop_front();
      2'd2: return q2.pop_front();
      2'd3: return q3.pop_front();
      default: return 32'd0;
    endcase
  endfunction

  function automatic void qpush(input logic [1:0] c, input logic [31:0] d);
    if (qsize(c) < FD) begin
      case (c)
        2'd1: q1.push_back(d);
        2'd2: q2.push_back(d);
        default: q3.push_back(d);
      endcase
    end else begin
      exp_ovf[c-2'd1] = 1'b1;
    end
  endfunction

  // Monitor: inputs and outputs seen here are what the next rising edge acts on
  always @(negedge clk) begin
    if (!rst) begin
      q1.delete(); q2.delete(); q3.delete();
      exp_ovf = 3'b000; fcnt = 0; fv_seen = 0; after_last = 0; prev_stall = 0;
      last_hs_cyc = -1;
    end else begin
      chk("ovf", 32'(ovf), 32'(exp_ovf));
      if (prev_stall) begin
        chk("hold_valid", 32'(out_t_valid), 32'd1);
        chk("hold_data", out_t_data, prev_data);
      end
      if (after_last) begin
        chk("gap_valid", 32'(out_t_valid), 32'd0);
        chk("gap_src", 32'(out_t_src), 32'd0);
      end
      after_last = 0;
      if (out_t_valid) begin
        if (!fv_seen) begin
          fv_seen = 1;
          fv_q.push_back(cyc);
          frame_src = out_t_src;
          chk("src_nonzero", 32'(out_t_src == 2'd0), 32'd0);
        end else begin
          chk("src_stable", 32'(out_t_src), 32'(frame_src));
        end
      end else begin
        chk("last_without_valid", 32'(out_t_last), 32'd0);
      end
      if (out_t_valid && out_t_ready) begin
        if (qsize(out_t_src) == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_word: got %0h on src %0d expected no word", out_t_data, out_t_src);
        end else begin
          chk("data", out_t_data, qpop(out_t_src));
        end
        chk("last", 32'(out_t_last), 32'(fcnt == FL - 1));
        if (fcnt == 0) begin
          fr_first.push_back(cyc);
          src_q.push_back(out_t_src);
          if (last_hs_cyc >= 0) gap_q.push_back(cyc - last_hs_cyc);
        end
        hs_total++;
        fcnt++;
        if (fcnt == FL) begin
          fcnt = 0; fv_seen = 0; after_last = 1; last_hs_cyc = cyc;
          fr_last.push_back(cyc);
        end
      end
      prev_stall = out_t_valid && !out_t_ready;
      prev_data  = out_t_data;
      if (adc1_t_valid) qpush(2'd1, adc1_t_data);
      if (adc2_t_valid) qpush(2'd2, adc2_t_data);
      if (adc3_t_valid) qpush(2'd3, adc3_t_data);
    end
  end

  task automatic drv(input logic [2:0] v, input logic [31:0] d1, d2, d3, input logic r);
    @(posedge clk);
    #1;
    adc1_t_valid = v[0]; adc1_t_data = d1;
    adc2_t_valid = v[1]; adc2_t_data = d2;
    adc3_t_valid = v[2]; adc3_t_data = d3;
    out_t_ready  = r;
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) drv(3'b000, 32'd0, 32'd0, 32'd0, r);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid"}, 32'(out_t_valid), 32'd0);
    chk({tag, "_last"}, 32'(out_t_last), 32'd0);
    chk({tag, "_src"}, 32'(out_t_src), 32'd0);
    chk({tag, "_data"}, out_t_data, 32'd0);
    chk({tag, "_ovf"}, 32'(ovf), 32'd0);
  endtask

  initial begin
    int h0, s0;
    logic [1:0] exp_seq [4];
    rst = 1'b0; src_sel = 2'd0; out_t_ready = 1'b0;
    adc1_t_valid = 1'b0; adc2_t_valid = 1'b0; adc3_t_valid = 1'b0;
    adc1_t_data = 32'd0; adc2_t_data = 32'd0; adc3_t_data = 32'd0;
    #3;
    chk_zero_outputs("reset");
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;

`ifdef BEAM_GATHER_RR_EN
    // Round-robin: all channels busy, expect 1,2,3,1 with one idle cycle between frames
    src_q.delete(); gap_q.delete();
    for (int i = 0; i < 45; i++) drv(3'b111, 32'h1000 + i, 32'h2000 + i, 32'h3000 + i, 1'b1);
    idle(10, 1'b1);
    exp_seq[0] = 2'd1; exp_seq[1] = 2'd2; exp_seq[2] = 2'd3; exp_seq[3] = 2'd1;
    if (src_q.size() < 4) miss("rr_frames");
    else for (int k = 0; k < 4; k++) chk("rr_src_seq", 32'(src_q[k]), 32'(exp_seq[k]));
    if (gap_q.size() < 3) miss("rr_gaps");
    else for (int k = 0; k < 3; k++) chk("rr_gap", 32'(gap_q[k]), 32'd2);
`else
    // Single frame, full rate
    src_sel = 2'd1;
    fv_q.delete(); fr_first.delete(); fr_last.delete(); src_q.delete();
    h0 = hs_total; s0 = 0;
    for (int i = 0; i < 8; i++) begin
      drv(3'b001, 32'(i), 32'd0, 32'd0, 1'b1);
      if (i == 0) s0 = cyc;
    end
    idle(6, 1'b1);
    chk("t1_count", 32'(hs_total - h0), 32'd8);
    if (fv_q.size() == 0) miss("t1_latency"); else chk("t1_latency", 32'(fv_q[0] - s0), 32'd2);
    if (fr_first.size() == 0 || fr_last.size() == 0) miss("t1_span");
    else chk("t1_span", 32'(fr_last[0] - fr_first[0]), 32'd7);
    if (src_q.size() == 0) miss("t1_src"); else chk("t1_src", 32'(src_q[0]), 32'd1);

    // Backpressure: ready toggles 1,0,1,0
    h0 = hs_total;
    for (int i = 0; i < 16; i++)
      drv((i % 2 == 0) ? 3'b001 : 3'b000, 32'h10 + 32'(i / 2), 32'd0, 32'd0, (i % 2 == 0));
    for (int i = 0; i < 16; i++) drv(3'b000, 32'd0, 32'd0, 32'd0, (i % 2 == 0));
    chk("t2_count", 32'(hs_total - h0), 32'd8);

    // Overflow while output disabled
    src_sel = 2'd0;
    for (int i = 0; i < 6; i++) drv(3'b010, 32'd0, 32'h100 + 32'(i), 32'd0, 1'b1);
    idle(4, 1'b1);
    chk("t3_ovf", 32'(ovf), 32'h2);
    chk("t3_idle_valid", 32'(out_t_valid), 32'd0);
    h0 = hs_total;
    src_sel = 2'd2;
    idle(8, 1'b1);
    chk("t3_count", 32'(hs_total - h0), 32'd4);
    for (int i = 0; i < 4; i++) drv(3'b010, 32'd0, 32'h200 + 32'(i), 32'd0, 1'b1);
    idle(8, 1'b1);
    chk("t3_frame", 32'(hs_total - h0), 32'd8);

    // Full FIFO accepts a write in the cycle a stall is released
    src_sel = 2'd1;
    for (int i = 0; i < 4; i++) drv(3'b001, 32'h300 + 32'(i), 32'd0, 32'd0, 1'b0);
    idle(3, 1'b0);
    h0 = hs_total;
    drv(3'b001, 32'h304, 32'd0, 32'd0, 1'b1);
    idle(2, 1'b0);
    chk("t4_ovf0", 32'(ovf[0]), 32'd0);
    chk("t4_one_pop", 32'(hs_total - h0), 32'd1);
    for (int i = 0; i < 3; i++) drv(3'b001, 32'h305 + 32'(i), 32'd0, 32'd0, 1'b1);
    idle(8, 1'b1);
    chk("t4_frame", 32'(hs_total - h0), 32'd8);
`endif

    // Randomized traffic and backpressure
    for (int i = 0; i < 600; i++) begin
      if (i % 40 == 0) src_sel = 2'($urandom_range(0, 3));
      drv({($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)},
          $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)));
    end
    idle(30, 1'b1);

    // Reset mid-frame
    @(posedge clk); #3 rst = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    src_sel = 2'd1;
    h0 = hs_total;
    for (int i = 0; i < 5; i++) drv(3'b001, 32'h400 + 32'(i), 32'd0, 32'd0, 1'b1);
    @(posedge clk);
    #3;
    adc1_t_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk_zero_outputs("midreset");
    chk("mid_frame", 32'((hs_total - h0) >= 1 && (hs_total - h0) <= 7), 32'd1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    src_q.delete();
    h0 = hs_total;
    for (int i = 0; i < 8; i++) drv(3'b001, 32'h500 + 32'(i), 32'd0, 32'd0, 1'b1);
    idle(12, 1'b1);
    chk("post_reset_frame", 32'(hs_total - h0), 32'd8);
    if (src_q.size() == 0) miss("post_reset_src"); else chk("post_reset_src", 32'(src_q[0]), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
